// File: rtl/seq_shifter8.sv
// ============================================================================
// Module      : seq_shifter8
// Description : Multi-cycle shifter, one bit position per clock, with
//               valid/ready handshakes on both the request and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shifter8 #(
    parameter  int WIDTH = 8,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    input  logic [SW-1:0]    s,
    input  logic [1:0]       t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SW-1:0] c_count_one = {{(SW-1){1'b0}}, 1'b1};

    state_t            r_state_q, w_state_d;
    logic [WIDTH-1:0]  r_q_q,     w_q_d;
    logic [SW-1:0]     r_count_q, w_count_d;
    logic [1:0]        r_mode_q,  w_mode_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_q_q     <= '0;
            r_count_q <= '0;
            r_mode_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_q_q     <= w_q_d;
            r_count_q <= w_count_d;
            r_mode_q  <= w_mode_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_q_d     = r_q_q;
        w_count_d = r_count_q;
        w_mode_d  = r_mode_q;

        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_q_d     = d;
                    w_count_d = s;
                    w_mode_d  = t;
                    w_state_d = (s == '0) ? ST_DONE : ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // mode[1] selects left; otherwise mode[0] picks the sign fill
                if (r_mode_q[1]) begin
                    w_q_d = {r_q_q[WIDTH-2:0], 1'b0};
                end else if (r_mode_q[0]) begin
                    w_q_d = {r_q_q[WIDTH-1], r_q_q[WIDTH-1:1]};
                end else begin
                    w_q_d = {1'b0, r_q_q[WIDTH-1:1]};
                end
                w_count_d = r_count_q - c_count_one;
                if (r_count_q == c_count_one) begin
                    w_state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = (r_state_q == ST_DONE);
    assign busy      = (r_state_q != ST_IDLE);
    assign q         = r_q_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shifter8.sv
// ============================================================================
// Module      : tb_seq_shifter8
// Description : Self-checking bench for seq_shifter8 against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shifter8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic [2:0] s;
    logic [1:0] t;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] q;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;
    bit check_en = 1'b0;

    seq_shifter8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .s         (s),
        .t         (t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_shift(input logic [7:0] dv, input int sv, input logic [1:0] tv);
        logic signed [7:0] sd;
        if (tv[1]) return 8'((dv << sv) & 8'hFF);
        if (tv[0]) begin
            sd = $signed(dv);
            return 8'(sd >>> sv);
        end
        return dv >> sv;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 shifting, 2 result held.
    int         m_phase = 0;
    int         m_k     = 0;
    int         m_s     = 0;
    logic [7:0] m_d     = '0;
    logic [1:0] m_t     = '0;
    logic [7:0] m_q     = '0;
    int         m_accepts = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_q     <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_d       <= d;
                    m_s       <= int'(s);
                    m_t       <= t;
                    m_k       <= 0;
                    m_q       <= d;
                    m_phase   <= (s == 3'd0) ? 2 : 1;
                    m_accepts <= m_accepts + 1;
                end
                1: begin
                    m_k     <= m_k + 1;
                    m_q     <= model_shift(m_d, m_k + 1, m_t);
                    if (m_k + 1 == m_s) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_in_ready",  32'(in_ready),  32'(m_phase == 0));
            chk("model_out_valid", 32'(out_valid), 32'(m_phase == 2));
            chk("model_busy",      32'(busy),      32'(m_phase != 0));
            chk("model_q",         32'(q),         32'(m_q));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("wait_idle_timeout", 32'(in_ready), 32'd1);
    endtask

    // Issue one request at a negedge; returns edges from accept to out_valid.
    task automatic issue(input logic [7:0] dv, input logic [2:0] sv, input logic [1:0] tv, output int lat);
        wait_idle();
        in_valid = 1'b1;
        d = dv; s = sv; t = tv;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic directed(input string name, input logic [7:0] dv, input logic [2:0] sv,
                            input logic [1:0] tv, input logic [7:0] exp);
        int lat;
        out_ready = 1'b1;
        issue(dv, sv, tv, lat);
        chk({name, "_q"},   32'(q),   32'(exp));
        chk({name, "_lat"}, 32'(lat), 32'(sv));
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [7:0] held_q;
        int cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d = '0; s = '0; t = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_q",         32'(q),         32'd0);
        check_en = 1'b1;

        directed("lsr_b4_3", 8'hB4, 3'd3, 2'b00, 8'h16);
        directed("asr_b4_3", 8'hB4, 3'd3, 2'b01, 8'hF6);
        directed("lsl_b4_3", 8'hB4, 3'd3, 2'b10, 8'hA0);
        directed("lsl11_b4", 8'hB4, 3'd3, 2'b11, 8'hA0);
        directed("asr_80_7", 8'h80, 3'd7, 2'b01, 8'hFF);
        directed("lsr_80_7", 8'h80, 3'd7, 2'b00, 8'h01);
        directed("s0_t00",   8'h5A, 3'd0, 2'b00, 8'h5A);
        directed("s0_t01",   8'h5A, 3'd0, 2'b01, 8'h5A);
        directed("s0_t10",   8'h5A, 3'd0, 2'b10, 8'h5A);

        // Backpressure in the result-held phase
        out_ready = 1'b0;
        issue(8'h3C, 3'd2, 2'b10, lat);
        held_q = q;
        chk("bp_q", 32'(held_q), 32'hF0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_q_stable",  32'(q),         32'(held_q));
            chk("bp_in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready",  32'(in_ready),  32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_q",         32'(q),         32'hF0);

        // Request while busy must be ignored
        wait_idle();
        in_valid = 1'b1; d = 8'hB4; s = 3'd5; t = 2'b00;
        @(negedge clk);
        d = 8'hFF; s = 3'd1; t = 2'b10;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_q", 32'(q), 32'h05);
        @(negedge clk);

        // Reset during shifting abandons the operation
        wait_idle();
        in_valid = 1'b1; d = 8'hB4; s = 3'd5; t = 2'b00;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_q",        32'(q),        32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_valid", 32'(out_valid), 32'd0);
        end

        // Randomized traffic; the per-cycle compare tracks every result
        cyc = 0;
        while (m_accepts < 1014 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            d         = 8'($urandom);
            s         = 3'($urandom);
            t         = 2'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("random_ops_completed", 32'(m_accepts >= 1014), 32'd1);
        out_ready = 1'b1;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
